// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder for the 1001 detector, MSB first, one-word skid.
// Optional parity bit after each word: define SERIALIZER_PARITY_EN.
module bit_stream_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full_q, full_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             x_d, xv_d;
`ifdef SERIALIZER_PARITY_EN
  logic             par_q, par_d;
  logic             hpar_q, hpar_d;
`endif

  logic xfer;
  logic div_end;
  logic bit_last;
  logic word_done;
  logic took;

  assign din_ready = !full_q;
  assign busy      = (state_q != IDLE) | full_q;
  assign xfer      = din_valid & din_ready;
  assign bit_last  = (bcnt_q == BW'(WIDTH - 1));
  assign div_end   = (DIV == 1) ? 1'b1
                   : (dcnt_q == DW'(DIV - 1));

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    hold_d    = hold_q;
    full_d    = full_q;
    bcnt_d    = bcnt_q;
    dcnt_d    = dcnt_q;
`ifdef SERIALIZER_PARITY_EN
    par_d     = par_q;
    hpar_d    = hpar_q;
`endif
    word_done = 1'b0;
    took      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          took    = 1'b1;
          sh_d    = din;
          bcnt_d  = '0;
          dcnt_d  = '0;
          state_d = SHIFT;
`ifdef SERIALIZER_PARITY_EN
          par_d   = ^din;
`endif
        end
      end
      SHIFT: begin
        if (div_end) begin
          dcnt_d = '0;
          if (bit_last) begin
            bcnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
            state_d = PARITY;
`else
            word_done = 1'b1;
`endif
          end else begin
            sh_d   = {sh_q[WIDTH-2:0], 1'b0};
            bcnt_d = bcnt_q + BW'(1);
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        if (div_end) begin
          dcnt_d    = '0;
          word_done = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // word end: drain the buffer, else take din directly, else go idle
    if (word_done) begin
      bcnt_d = '0;
      dcnt_d = '0;
      if (full_q) begin
        sh_d    = hold_q;
        full_d  = 1'b0;
        state_d = SHIFT;
`ifdef SERIALIZER_PARITY_EN
        par_d   = hpar_q;
`endif
      end else if (xfer) begin
        took    = 1'b1;
        sh_d    = din;
        state_d = SHIFT;
`ifdef SERIALIZER_PARITY_EN
        par_d   = ^din;
`endif
      end else begin
        state_d = IDLE;
      end
    end

    if (xfer && !took) begin
      hold_d = din;
      full_d = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      hpar_d = ^din;
`endif
    end

    xv_d = (state_d != IDLE);
    x_d  = 1'b0;
    if (state_d == SHIFT) begin
      x_d = sh_d[WIDTH-1];
    end
`ifdef SERIALIZER_PARITY_EN
    if (state_d == PARITY) begin
      x_d = par_d;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      bcnt_q  <= '0;
      dcnt_q  <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
      hpar_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      bcnt_q  <= bcnt_d;
      dcnt_q  <= dcnt_d;
      x       <= x_d;
      x_valid <= xv_d;
`ifdef SERIALIZER_PARITY_EN
      par_q   <= par_d;
      hpar_q  <= hpar_d;
`endif
    end
  end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer: DIV=1 and DIV=3 instances,
// vector table plus scoreboard of expected serial bits.
module tb_bit_stream_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 8 + PAR;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din0, din1;
  logic [1:0] dv, rdy, xo, xv, bsy;

  int checks = 0;
  int errors = 0;
  int vcnt[2];
  bit q0[$];
  bit q1[$];

  typedef struct {
    logic [7:0] din;
    logic       par;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  bit_stream_serializer #(.WIDTH(8), .DIV(1)) u0 (
    .clk(clk), .reset(rst_n),
    .din(din0), .din_valid(dv[0]),
    .din_ready(rdy[0]), .x(xo[0]),
    .x_valid(xv[0]), .busy(bsy[0])
  );

  bit_stream_serializer #(.WIDTH(8), .DIV(3)) u1 (
    .clk(clk), .reset(rst_n),
    .din(din1), .din_valid(dv[1]),
    .din_ready(rdy[1]), .x(xo[1]),
    .x_valid(xv[1]), .busy(bsy[1])
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic push(input int s, input logic [7:0] w,
                      input logic p);
    int d;
    d = (s == 0) ? 1 : 3;
    for (int i = 7; i >= 0; i--)
      for (int k = 0; k < d; k++)
        if (s == 0) q0.push_back(w[i]);
        else q1.push_back(w[i]);
    if (PAR != 0)
      for (int k = 0; k < d; k++)
        if (s == 0) q0.push_back(p);
        else q1.push_back(p);
  endtask

  // offers w until a handshake edge; returns number of stalled edges
  task automatic send(input int s, input logic [7:0] w,
                      input logic p, output int stalls);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    if (s == 0) din0 = w;
    else din1 = w;
    dv[s] = 1'b1;
    while (!ok && n < 200) begin
      @(posedge clk);
      if (rdy[s]) ok = 1'b1;
      else n++;
    end
    if (ok) begin
      push(s, w, p);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d: din_ready=0, need 1", s);
    end
    stalls = n;
    #1 dv[s] = 1'b0;
  endtask

  task automatic wait_idle(input int s);
    int n;
    int qs;
    n  = 0;
    qs = (s == 0) ? q0.size() : q1.size();
    while ((qs != 0 || bsy[s]) && n < 1000) begin
      @(negedge clk);
      n++;
      qs = (s == 0) ? q0.size() : q1.size();
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout dut%0d: busy=%0b q=%0d, need idle",
               s, bsy[s], qs);
    end
    @(negedge clk);
    check("idle_xv", {31'd0, xv[s]}, 32'd0);
    check("idle_x", {31'd0, xo[s]}, 32'd0);
    check("idle_busy", {31'd0, bsy[s]}, 32'd0);
    check("idle_rdy", {31'd0, rdy[s]}, 32'd1);
  endtask

  initial begin
    int st;
    int n;
    rst_n   = 1'b0;
    dv      = 2'b00;
    din0    = 8'h00;
    din1    = 8'h00;
    vcnt[0] = 0;
    vcnt[1] = 0;
    tbl[0]  = '{8'h99, 1'b0};
    tbl[1]  = '{8'h07, 1'b1};
    tbl[2]  = '{8'hA5, 1'b0};
    tbl[3]  = '{8'h80, 1'b1};
    tbl[4]  = '{8'hFF, 1'b0};
    tbl[5]  = '{8'h00, 1'b0};

    fork
      forever begin
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
          int qs;
          bit e;
          qs = (s == 0) ? q0.size() : q1.size();
          if (xv[s]) begin
            vcnt[s]++;
            if (qs == 0) begin
              checks++;
              errors++;
              $display("FAIL extra_bit dut%0d: x_valid=1, need 0", s);
            end else begin
              if (s == 0) e = q0.pop_front();
              else e = q1.pop_front();
              check($sformatf("x_bit_dut%0d", s),
                    {31'd0, xo[s]}, {31'd0, e});
            end
          end else begin
            check("x_zero_when_invalid", {31'd0, xo[s]}, 32'd0);
            if (qs != 0) begin
              checks++;
              errors++;
              $display("FAIL gap dut%0d: x_valid=0, need 1", s);
            end
          end
        end
      end
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
      end
    join_none

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_x", {31'd0, xo[s]}, 32'd0);
      check("rst_xv", {31'd0, xv[s]}, 32'd0);
      check("rst_busy", {31'd0, bsy[s]}, 32'd0);
      check("rst_rdy", {31'd0, rdy[s]}, 32'd1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // single words, idle between
    for (int i = 0; i < 6; i++) begin
      vcnt[0] = 0;
      send(0, tbl[i].din, tbl[i].par, st);
      check("single_stall", st, 0);
      wait_idle(0);
      check("single_len", vcnt[0], NB);
    end

    // back-to-back through the holding buffer
    vcnt[0] = 0;
    send(0, 8'h99, 1'b0, st);
    send(0, 8'h0F, 1'b0, st);
    check("b2b_rdy_low", {31'd0, rdy[0]}, 32'd0);
    check("b2b_busy", {31'd0, bsy[0]}, 32'd1);
    n = 0;
    while (!rdy[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b2b_rdy_low_cycles", n, NB);
    wait_idle(0);
    check("b2b_len", vcnt[0], 2 * NB);

    // backpressure: third word stalls until first word ends
    vcnt[0] = 0;
    send(0, 8'hA5, 1'b0, st);
    send(0, 8'h3C, 1'b0, st);
    send(0, 8'hFF, 1'b0, st);
    check("bp_stalls", st, NB - 1);
    wait_idle(0);
    check("bp_len", vcnt[0], 3 * NB);

    // empty buffer, new word lands exactly on the word-end edge
    vcnt[0] = 0;
    send(0, 8'h3C, 1'b0, st);
    repeat (NB - 1) @(posedge clk);
    #1;
    send(0, 8'h81, 1'b0, st);
    check("edge_load_stall", st, 0);
    wait_idle(0);
    check("edge_load_len", vcnt[0], 2 * NB);

    // DIV=3
    @(negedge clk);
    vcnt[1] = 0;
    send(1, 8'h81, 1'b0, st);
    wait_idle(1);
    check("div3_len", vcnt[1], 3 * NB);

    // reset in the middle of a word with a held word
    @(negedge clk);
    vcnt[0] = 0;
    send(0, 8'h99, 1'b0, st);
    send(0, 8'h55, 1'b0, st);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_x", {31'd0, xo[0]}, 32'd0);
    check("mid_rst_xv", {31'd0, xv[0]}, 32'd0);
    check("mid_rst_rdy", {31'd0, rdy[0]}, 32'd1);
    check("mid_rst_busy", {31'd0, bsy[0]}, 32'd0);
    q0.delete();
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    vcnt[0] = 0;
    repeat (20) @(negedge clk);
    check("post_rst_no_bits", vcnt[0], 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
